// File: rtl/phv_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : phv_operand_stage
// Purpose  : Selects two 32-bit PHV fields as stateful-atom operands, tags each
//            accepted PHV with a sequence number and buffers up to two pairs.
//            Optional accepted-packet counter under macro OPERAND_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module phv_operand_stage #(
    parameter int SEQ_W   = 8,
    parameter int STATS_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_phv,
    input  logic [1:0]         field_sel_1,
    input  logic [1:0]         field_sel_2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        pkt_1,
    output logic [31:0]        pkt_2,
    output logic [SEQ_W-1:0]   out_seq
`ifdef OPERAND_STATS_EN
    ,
    output logic [STATS_W-1:0] stat_count
`endif
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             w_pop;
    logic [31:0]      w_fld_1;
    logic [31:0]      w_fld_2;
    logic [SEQ_W-1:0] r_seq;

    // Head entry drives the outputs directly; r_sec_* holds the younger entry.
    logic [31:0]      r_head_1;
    logic [31:0]      r_head_2;
    logic [SEQ_W-1:0] r_head_seq;
    logic [31:0]      r_sec_1;
    logic [31:0]      r_sec_2;
    logic [SEQ_W-1:0] r_sec_seq;

    assign in_ready  = (r_state != c_TWO);
    assign out_valid = (r_state != c_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_fld_1 = in_phv[{field_sel_1, 5'd0} +: 32];
    assign w_fld_2 = in_phv[{field_sel_2, 5'd0} +: 32];

    assign pkt_1   = r_head_1;
    assign pkt_2   = r_head_2;
    assign out_seq = r_head_seq;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_EMPTY: if (w_accept) w_state_nxt = c_ONE;
            c_ONE: begin
                if (w_accept && !w_pop)      w_state_nxt = c_TWO;
                else if (!w_accept && w_pop) w_state_nxt = c_EMPTY;
            end
            c_TWO:   if (w_pop) w_state_nxt = c_ONE;
            default: w_state_nxt = c_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq <= '0;
        end else if (w_accept) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_1   <= '0;
            r_head_2   <= '0;
            r_head_seq <= '0;
            r_sec_1    <= '0;
            r_sec_2    <= '0;
            r_sec_seq  <= '0;
        end else begin
            // New data lands in the head when the head is free or being popped
            // with nothing behind it; otherwise it queues in the second slot.
            if (r_state == c_TWO && w_pop) begin
                r_head_1   <= r_sec_1;
                r_head_2   <= r_sec_2;
                r_head_seq <= r_sec_seq;
            end else if (w_accept && (r_state == c_EMPTY || w_pop)) begin
                r_head_1   <= w_fld_1;
                r_head_2   <= w_fld_2;
                r_head_seq <= r_seq;
            end else if (w_accept) begin
                r_sec_1    <= w_fld_1;
                r_sec_2    <= w_fld_2;
                r_sec_seq  <= r_seq;
            end
        end
    end

`ifdef OPERAND_STATS_EN
    logic [STATS_W-1:0] r_stat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat <= '0;
        end else if (w_accept && (r_stat != {STATS_W{1'b1}})) begin
            r_stat <= r_stat + 1'b1;
        end
    end

    assign stat_count = r_stat;
`endif

endmodule
`default_nettype wire

// File: doc/phv_operand_stage.md
PHV_OPERAND_STAGE -- requirements
Module: phv_operand_stage

Interface
REQ-001 Parameter SEQ_W, default 8: width of the per-packet sequence tag.
REQ-002 Parameter STATS_W, default 16: width of the accepted-packet statistics counter.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  upstream PHV present.
REQ-007 in_ready  output  1  stage can accept a PHV this cycle.
REQ-008 in_phv  input  128  four 32-bit fields; field k occupies bits [32k+31:32k].
REQ-009 field_sel_1  input  2  field index routed to pkt_1.
REQ-010 field_sel_2  input  2  field index routed to pkt_2.
REQ-011 out_valid  output  1  operand pair available to the stateful atom.
REQ-012 out_ready  input  1  atom consumes the pair this cycle.
REQ-013 pkt_1  output  32  first atom operand.
REQ-014 pkt_2  output  32  second atom operand.
REQ-015 out_seq  output  SEQ_W  sequence tag of the pair on pkt_1/pkt_2.
REQ-016 stat_count  output  STATS_W  accepted-packet count; present only with OPERAND_STATS_EN.

Function
REQ-017 Accept SHALL occur when in_valid && in_ready at a rising edge; pop SHALL occur when out_valid && out_ready.
REQ-018 Storage SHALL be a 2-entry FIFO of {pkt_1, pkt_2, seq} with occupancy FSM states EMPTY, ONE, TWO.
REQ-019 Transitions: EMPTY+accept->ONE; ONE+accept only->TWO; ONE+pop only->EMPTY; ONE+accept+pop->ONE; TWO+pop->ONE; all other cases hold state.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; in_ready SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL be 1 exactly in ONE and TWO; pkt_1, pkt_2 and out_seq SHALL present the oldest entry.
REQ-022 Field selection SHALL use field_sel_1/field_sel_2 sampled at the accept edge; later changes SHALL NOT alter stored entries.
REQ-023 Latency from accept to out_valid SHALL be exactly one cycle when the FIFO is empty.
REQ-024 Equal field_sel_1 and field_sel_2 values SHALL be legal and SHALL give pkt_1 == pkt_2.
REQ-025 Sequence counter SHALL tag each accepted PHV with its current value, then increment modulo 2^SEQ_W (255 wraps to 0 at default).
REQ-026 Output data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 An in_valid asserted while in_ready=0 SHALL be ignored: no state change and no sequence increment.

Reset
REQ-028 When rst=1 at a clock edge, the FSM SHALL go to EMPTY, out_valid SHALL be 0, in_ready SHALL be 1 in the following cycle, the sequence counter SHALL be 0, and stat_count (if present) SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all stored entries; rst SHALL take priority over a simultaneous accept or pop.
REQ-030 pkt_1, pkt_2 and out_seq SHALL reset to 0.

Configuration
REQ-031 With macro OPERAND_STATS_EN defined, stat_count SHALL increment by 1 per accept and saturate at 2^STATS_W-1.
REQ-032 Without OPERAND_STATS_EN, the stat_count port and its counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Single PHV with fields {0x11,0x22,0x33,0x44}, sel_1=2, sel_2=0, out_ready=1 -> next cycle out_valid=1, pkt_1=0x33, pkt_2=0x11, out_seq=0.
REQ-034 out_ready=0 with three back-to-back PHVs -> first two accepted, in_ready=0 on the third cycle, the third PHV is not consumed, and seq values are 0 and 1.
REQ-035 State ONE with simultaneous accept and pop -> state remains ONE and the new entry appears next with out_seq incremented.
REQ-036 300 accepts with out_ready=1 -> out_seq reaches 255, then 0, then ends at 43; with OPERAND_STATS_EN, stat_count=300.
REQ-037 rst=1 asserted in state TWO alongside in_valid=1 -> next cycle out_valid=0, in_ready=1, seq=0, and the flushed PHVs never appear at the output.
REQ-038 field_sel changed while an entry is stalled -> pkt_1/pkt_2 keep their captured values until the pop.
